// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: emulated DVP camera producing framed RGB565 test patterns
module dvp_pattern_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        pclk,
  output logic        vs,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
  localparam logic [15:0] H_LAST = 16'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] H_VIS  = 16'(2 * H_ACTIVE);
  localparam logic [15:0] BAR_W  = 16'(H_ACTIVE / 8);
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  state_t      state_q, state_d;
  logic        pclk_q, pclk_d;
  logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] solid_q, solid_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        tick, line_end, phase_end, start;
  logic [15:0] v_last, x, pix;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pclk_q       <= 1'b0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      mode_q       <= '0;
      solid_q      <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pclk_q       <= pclk_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      mode_q       <= mode_d;
      solid_q      <= solid_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end
  always_comb begin
    pclk_d       = ~pclk_q;
    tick         = pclk_q;
    state_d      = state_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    mode_d       = mode_q;
    solid_d      = solid_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    line_end     = h_cnt_q == H_LAST;
    v_last       = state_q == VSYNC  ? 16'(V_SYNC - 1)   :
                   state_q == VBACK  ? 16'(V_BACK - 1)   :
                   state_q == ACTIVE ? 16'(V_ACTIVE - 1) : 16'(V_FRONT - 1);
    phase_end    = line_end && v_cnt_q == v_last;
    if (tick && state_q != IDLE) begin
      h_cnt_d = line_end ? '0 : h_cnt_q + 16'd1;
      v_cnt_d = phase_end ? '0 : line_end ? v_cnt_q + 16'd1 : v_cnt_q;
      if (phase_end) begin
        case (state_q)
          VSYNC:   state_d = VBACK;
          VBACK:   state_d = ACTIVE;
          ACTIVE:  state_d = VFRONT;
          VFRONT: begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
    // enable matters only when a frame may begin; mode/colour freeze here
    start = tick && enable && (state_q == IDLE || (state_q == VFRONT && phase_end));
    if (start) begin
      state_d = VSYNC;
      mode_d  = mode;
      solid_d = solid_color;
    end
  end
  always_comb begin
    x          = h_cnt_q >> 1;
    pix        = mode_q == 2'd0 ? BARS[3'(x / BAR_W)] :
                 mode_q == 2'd1 ? x + v_cnt_q :
                 mode_q == 2'd2 ? {16{x[5] ^ v_cnt_q[5] ^ frame_cnt_q[0]}} : solid_q;
    pclk       = pclk_q;
    vs         = state_q == VSYNC;
    href       = state_q == ACTIVE && h_cnt_q < H_VIS;
    data       = href ? (h_cnt_q[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    frame_done = frame_done_q;
    frame_cnt  = frame_cnt_q;
  end
endmodule
